// File: rtl/sd_cmd_seq.sv
// SPI-mode SD command sequencer: frames a 6-byte command, polls with 0xFF filler for R1, owns chip select.
// Latency: start to done is 8*(7+p) sclk for an R1 on poll slot p; 8*(7+RESP_TIMEOUT) on timeout.
// Backpressure: none; start is only sampled in IDLE. Define SD_CRC7_EN to compute CRC7 in place of constant CRC bytes.
module sd_cmd_seq #(
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic [7:0]  rx_byte,
    output logic [7:0]  tx_byte,
    output logic        cs_n,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_POLL,
        S_TAIL,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  r_byte_idx;
    logic [7:0]  r_poll_cnt;
    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    logic [7:0]  r_tx_byte;
    logic        r_cs_n;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_r1;
    logic        r_timeout;

    logic        w_boundary;
    logic [7:0]  w_crc_byte;
    logic [7:0]  w_nxt_byte;

`ifdef SD_CRC7_EN
    logic [6:0]  r_crc;
    logic        w_crc_fb;
    logic [6:0]  w_crc_nxt;

    // Serial CRC7 step over the bit currently on the wire; the last bit is folded in combinationally at the byte4 boundary
    always_comb begin
        w_crc_fb   = r_tx_byte[3'd7 - r_bit_cnt] ^ r_crc[6];
        w_crc_nxt  = {r_crc[5:3], r_crc[2] ^ w_crc_fb, r_crc[1:0], w_crc_fb};
        w_crc_byte = {w_crc_nxt, 1'b1};
    end
`else
    // Fixed CRC bytes: only CMD0 and CMD8 are checked by a card in SPI mode
    always_comb begin
        case (r_idx)
            6'd0:    w_crc_byte = 8'h95;
            6'd8:    w_crc_byte = 8'h87;
            default: w_crc_byte = 8'h01;
        endcase
    end
`endif

    // Frame byte that follows the one currently presented
    always_comb begin
        w_boundary = (r_bit_cnt == 3'd7);
        case (r_byte_idx)
            3'd0:    w_nxt_byte = r_arg[31:24];
            3'd1:    w_nxt_byte = r_arg[23:16];
            3'd2:    w_nxt_byte = r_arg[15:8];
            3'd3:    w_nxt_byte = r_arg[7:0];
            default: w_nxt_byte = w_crc_byte;
        endcase
    end

    // Command sequencing FSM with registered outputs
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_byte_idx <= 3'd0;
            r_poll_cnt <= 8'd0;
            r_idx      <= 6'd0;
            r_arg      <= 32'd0;
            r_tx_byte  <= 8'hFF;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_r1       <= 8'hFF;
            r_timeout  <= 1'b0;
`ifdef SD_CRC7_EN
            r_crc      <= 7'd0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx      <= cmd_idx;
                        r_arg      <= cmd_arg;
                        r_r1       <= 8'hFF;
                        r_timeout  <= 1'b0;
                        r_cs_n     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_tx_byte  <= {2'b01, cmd_idx};
                        r_byte_idx <= 3'd0;
                        r_state    <= S_SEND;
`ifdef SD_CRC7_EN
                        r_crc      <= 7'd0;
`endif
                    end
                end
                S_SEND: begin
`ifdef SD_CRC7_EN
                    if (r_byte_idx <= 3'd4) begin
                        r_crc <= w_crc_nxt;
                    end
`endif
                    if (w_boundary) begin
                        if (r_byte_idx == 3'd5) begin
                            r_tx_byte  <= 8'hFF;
                            r_poll_cnt <= 8'd0;
                            r_state    <= S_POLL;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_tx_byte  <= w_nxt_byte;
                        end
                    end
                end
                S_POLL: begin
                    if (w_boundary) begin
                        if (!rx_byte[7]) begin
                            r_r1    <= rx_byte;
                            r_state <= S_TAIL;
                        end else if ((r_poll_cnt + 8'd1) == 8'(RESP_TIMEOUT)) begin
                            r_timeout <= 1'b1;
                            r_r1      <= 8'hFF;
                            r_state   <= S_TAIL;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + 8'd1;
                        end
                    end
                end
                S_TAIL: begin
                    if (w_boundary) begin
                        r_cs_n  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    // Done cycle: drop busy and return to IDLE with counters cleared
                    r_busy     <= 1'b0;
                    r_bit_cnt  <= 3'd0;
                    r_byte_idx <= 3'd0;
                    r_poll_cnt <= 8'd0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_byte = r_tx_byte;
    assign cs_n    = r_cs_n;
    assign busy    = r_busy;
    assign done    = r_done;
    assign r1      = r_r1;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Bench for sd_cmd_seq: directed commands plus random commands/responses against a slot-level reference model.
// Latency: expected done cycle is derived from the frame length, poll slot of the first R1 and the timeout limit.
// Backpressure: a start pulse injected mid-command must leave the frame untouched.
module tb_sd_cmd_seq;

    localparam int RT    = 8;
    localparam int LIMIT = 8 * (8 + RT) + 8;

    logic        sclk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        cs_n;
    logic        busy;
    logic        done;
    logic [7:0]  r1;
    logic        timeout;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  resp [0:15];

    sd_cmd_seq #(.RESP_TIMEOUT(RT)) dut (
        .sclk    (sclk),
        .reset   (reset),
        .start   (start),
        .cmd_idx (cmd_idx),
        .cmd_arg (cmd_arg),
        .rx_byte (rx_byte),
        .tx_byte (tx_byte),
        .cs_n    (cs_n),
        .busy    (busy),
        .done    (done),
        .r1      (r1),
        .timeout (timeout)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    // CRC byte of the frame, from the SD rules (CRC7 over the first 40 bits, or fixed constants)
    function automatic logic [7:0] crc_byte(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CRC7_EN
        logic [39:0] m;
        int          c;
        int          fb;
        m = {2'b01, idx, arg};
        c = 0;
        for (int i = 39; i >= 0; i--) begin
            fb = int'(m[i]) ^ ((c >> 6) & 1);
            c  = ((c << 1) & 8'h7F) ^ (fb != 0 ? 9 : 0);
        end
        return {c[6:0], 1'b1};
`else
        if (idx == 6'd0) return 8'h95;
        if (idx == 6'd8) return 8'h87;
        return 8'h01;
`endif
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"},   tx_byte, 8'hFF);
        chk({tag, "_cs_n"}, cs_n, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    // Issue one command, feed resp[] one per poll slot, check every byte slot and completion
    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg, input int ign_at);
        logic [7:0] frame [0:5];
        int         p;
        int         exp_c;
        logic [7:0] exp_r1;
        logic       exp_to;
        int         c;
        int         s;

        frame[0] = {2'b01, idx};
        frame[1] = arg[31:24];
        frame[2] = arg[23:16];
        frame[3] = arg[15:8];
        frame[4] = arg[7:0];
        frame[5] = crc_byte(idx, arg);

        p = 0;
        for (int k = 1; k <= RT; k++) begin
            if (p == 0 && resp[k-1][7] == 1'b0) p = k;
        end
        exp_to = (p == 0);
        exp_r1 = exp_to ? 8'hFF : resp[p-1];
        exp_c  = exp_to ? 8 * (7 + RT) : 8 * (7 + p);

        cmd_idx = idx;
        cmd_arg = arg;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        cmd_idx = 6'($urandom);
        cmd_arg = $urandom;

        c = 0;
        while (c < LIMIT && !done) begin
            s = c / 8;
            rx_byte = (s >= 6 && s - 6 < 16) ? resp[s-6] : 8'hFF;
            if (c % 8 == 4) begin
                chk({tag, "_tx"},   tx_byte, (s < 6) ? frame[s] : 8'hFF);
                chk({tag, "_cs_n"}, cs_n, 1'b0);
                chk({tag, "_busy"}, busy, 1'b1);
            end
            start = (c == ign_at) ? 1'b1 : 1'b0;
            tick();
            c++;
        end
        start = 1'b0;

        chk({tag, "_done_cycle"}, c, exp_c);
        chk({tag, "_r1"}, r1, exp_r1);
        chk({tag, "_timeout"}, timeout, exp_to);
        chk({tag, "_cs_n_at_done"}, cs_n, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b1);
        rx_byte = 8'hFF;
        tick();
        chk_idle({tag, "_after"});
        chk({tag, "_r1_held"}, r1, exp_r1);
        chk({tag, "_timeout_held"}, timeout, exp_to);
    endtask

    task automatic fill_resp(input int p);
        for (int k = 0; k < 16; k++) begin
            resp[k] = 8'($urandom) | 8'h80;
        end
        if (p >= 1 && p <= 16) resp[p-1] = 8'($urandom) & 8'h7F;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        cmd_idx = 6'd0;
        cmd_arg = 32'd0;
        rx_byte = 8'hFF;

        // Reset state
        #12;
        chk_idle("reset");
        chk("reset_r1", r1, 8'hFF);
        chk("reset_timeout", timeout, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk_idle("post_reset");

        // CMD0, R1=0x01 on first poll
        for (int k = 0; k < 16; k++) resp[k] = 8'hFF;
        resp[0] = 8'h01;
        run_cmd("cmd0", 6'd0, 32'h0000_0000, -1);

        // CMD8, two 0xFF polls then 0x01
        for (int k = 0; k < 16; k++) resp[k] = 8'hFF;
        resp[2] = 8'h01;
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, -1);

        // Timeout with rx held 0xFF, start pulsed mid-frame
        for (int k = 0; k < 16; k++) resp[k] = 8'hFF;
        run_cmd("tmo", 6'd17, 32'h1234_5678, 20);

        // CMD55 / ACMD41
        for (int k = 0; k < 16; k++) resp[k] = 8'hFF;
        resp[0] = 8'h01;
        run_cmd("cmd55", 6'd55, 32'h0000_0000, -1);
        run_cmd("acmd41", 6'd41, 32'h4000_0000, 30);

        // R1 of 0x00 is valid
        for (int k = 0; k < 16; k++) resp[k] = 8'hFF;
        resp[3] = 8'h00;
        run_cmd("r1_zero", 6'd17, 32'h0000_0200, -1);

        // Reset mid-SEND (byte2)
        cmd_idx = 6'd24;
        cmd_arg = 32'hDEAD_BEEF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("pre_abort_tx", tx_byte, 8'hAD);
        reset = 1'b1;
        #1;
        chk_idle("abort");
        chk("abort_r1", r1, 8'hFF);
        chk("abort_timeout", timeout, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i % 6 == 5) chk_idle("abort_quiet");
        end

        // Random commands and responses, including timeouts
        for (int n = 0; n < 12; n++) begin
            fill_resp($urandom_range(1, RT + 2));
            run_cmd("rand", 6'($urandom), $urandom, (n % 3 == 0) ? int'($urandom_range(0, 60)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_cmd_seq.md
# sd_cmd_seq

SPI-mode SD command sequencer that sits directly upstream of the byte shift stage in the MicroSD path. It frames a 6-byte SD command (start/index, 32-bit argument, CRC byte), feeds it byte-by-byte to the shifter's parallel load input, and polls with 0xFF filler bytes until an R1 response or timeout. It owns chip select and reports completion to the host FSM.

## Interface
- RESP_TIMEOUT, 8: maximum number of 0xFF poll bytes sent while waiting for R1 (NCR limit); legal range 1..255.
- sclk  in  1  SPI bit clock, shared with the shift stage; all logic on posedge.
- reset  in  1  reset, asynchronous, active-high; clock sclk.
- start  in  1  command request; sampled only in IDLE.
- cmd_idx  in  6  SD command index.
- cmd_arg  in  32  command argument, MSB first on the wire.
- rx_byte  in  8  byte received by the shift stage during the last completed byte slot.
- tx_byte  out  8  byte presented to the shift stage's parallel load input.
- cs_n  out  1  SD chip select, active-low.
- busy  out  1  high from accepted start until the done cycle inclusive.
- done  out  1  one-cycle completion pulse.
- r1  out  8  captured R1 response; held until next accepted start.
- timeout  out  1  set with done when no R1 arrived; held until next accepted start.

## Operation
- Reset values: tx_byte=0xFF, cs_n=1, busy=0, done=0, r1=0xFF, timeout=0; state IDLE, counters 0. Reset mid-command aborts immediately to these values; no trailing bytes sent.
- Bit counter 0..7 advances every sclk in non-IDLE states; a "byte boundary" is the edge where it wraps 7→0. tx_byte changes and rx_byte is sampled only at byte boundaries.
- Frame: byte0={2'b01,cmd_idx}, byte1..4=cmd_arg[31:24]..[7:0], byte5=CRC byte (see Configuration).
- States:
  - IDLE: cs_n=1, tx_byte=0xFF. On start=1: latch cmd_idx/cmd_arg, clear r1 to 0xFF and timeout to 0, cs_n←0, busy←1, tx_byte←byte0, byte index←0, go SEND.
  - SEND: at each boundary present next frame byte; at boundary after byte5, tx_byte←0xFF, poll count←0, go POLL.
  - POLL: at each boundary inspect rx_byte (response to the slot just completed). rx_byte[7]==0 → r1←rx_byte, go TAIL. Else poll count+1; if it reaches RESP_TIMEOUT → timeout←1, r1←0xFF, go TAIL. tx_byte stays 0xFF.
  - TAIL: one extra 0xFF byte with cs_n low (Ncr/Nec clocks). At its boundary: cs_n←1, done←1 for one cycle, busy←0 the following cycle, go IDLE.
- start while busy is ignored; start held high through done re-triggers only after IDLE is re-entered (next edge after done).
- rx_byte arriving as 0x00 is a valid R1; 0xFF never is.

## Timing
- Start accepted at edge E0; byte k of frame on tx_byte from E0+8k.
- R1 found on poll slot p (1-based): TAIL starts at E0+8(6+p); done high in the cycle after edge E0+8(7+p); minimum start-to-done = 64 sclk (p=1).
- Timeout: done after E0+8(7+RESP_TIMEOUT).
- Back-to-back: next start may be accepted the edge after done deasserts; cs_n is high for at least one sclk between commands.

## Configuration
- SD_CRC7_EN defined: CRC byte = {CRC7(x^7+x^3+1) over bytes0..4 MSB first, 1'b1}, computed serially during SEND, ready by byte5 boundary.
- SD_CRC7_EN undefined: CRC byte from constants: 0x95 for cmd_idx 0, 0x87 for cmd_idx 8, 0x01 otherwise (SPI mode ignores CRC after CMD0/CMD8).

## Test plan
- CMD0 arg 0x00000000, rx_byte=0x01 on first poll → tx sequence 40 00 00 00 00 95 FF FF, r1=0x01, timeout=0, done 64 sclk after start, cs_n high after.
- CMD8 arg 0x000001AA, rx_byte 0xFF for 2 polls then 0x01 → CRC byte 0x87, r1=0x01, done at 80 sclk.
- SD_CRC7_EN defined: CMD55 arg 0 → CRC byte 0x65; ACMD41 arg 0x40000000 → CRC byte 0x77.
- RESP_TIMEOUT=8, rx_byte held 0xFF → 8 poll bytes, timeout=1, r1=0xFF, done at start+120 sclk.
- Reset asserted mid-SEND (byte2) → outputs to reset values same instant; start pulsed during busy → ignored, frame unchanged.
